// File: rtl/parking_gate_controller.sv
// ---------------------------------------------------------------------------
// parking_gate_controller
//
// Sequences the single shared entry/exit barrier of the car park. Exit
// requests win over entry requests. An entering car gets the lowest-numbered
// slot that is neither occupied nor reserved, and that slot stays reserved
// until its occupancy sensor sees the car. A barrier left open for
// OPEN_CYCLES cycles without gate_clear times out. If that happens during an
// entry, the entering car's reservation is dropped.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   cars          slot occupancy sensors, bit i = slot i+1
//   entry_req     level request from the entry button
//   exit_req      level request from the exit reader
//   exit_slot     slot being vacated (1..NUM_SLOTS valid)
//   gate_clear    pulse from the barrier beam once a car has passed
//   entry_grant   one-cycle pulse when a slot is allocated
//   exit_ack      one-cycle pulse when an exit request is accepted
//   assigned_slot last allocated slot number, 0 when none
//   gate_open     barrier open command
//   full          every slot is occupied or reserved (combinational)
//   reserved      reservation mask, bit i = slot i+1
// ---------------------------------------------------------------------------
module parking_gate_controller #(
   parameter int NUM_SLOTS   = 15,
   parameter int SLOT_W      = 4,
   parameter int OPEN_CYCLES = 8,
   parameter int CNT_W       = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_SLOTS-1:0] cars,
   input  logic                 entry_req,
   input  logic                 exit_req,
   input  logic [SLOT_W-1:0]    exit_slot,
   input  logic                 gate_clear,
   output logic                 entry_grant,
   output logic                 exit_ack,
   output logic [SLOT_W-1:0]    assigned_slot,
   output logic                 gate_open,
   output logic                 full,
   output logic [NUM_SLOTS-1:0] reserved
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ENTRY_OPEN = 2'd1,
      EXIT_OPEN  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_SLOTS-1:0] reserved_q, reserved_d;
   logic [SLOT_W-1:0]    assigned_slot_q, assigned_slot_d;
   logic                 entry_grant_q, entry_grant_d;
   logic                 exit_ack_q, exit_ack_d;
   logic                 gate_open_q, gate_open_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic [NUM_SLOTS-1:0] avail;
   logic [SLOT_W-1:0]    free_idx;
   logic                 exit_valid;
   logic                 timeout;

   // One-hot mask for a 1-based slot number. Slot 0 and out-of-range
   // numbers give an empty mask.
   function automatic logic [NUM_SLOTS-1:0] slot_mask(input logic [SLOT_W-1:0] slot);
      logic [NUM_SLOTS-1:0] m;
      m = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         m[i] = (slot == SLOT_W'(i + 1));
      end
      return m;
   endfunction

   // Free-slot search. The loop runs downward, so the lowest free slot
   // is the last one written and wins. Slot 1 has the highest priority.
   always_comb begin
      avail    = ~(cars | reserved_q);
      free_idx = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (avail[i]) begin
            free_idx = SLOT_W'(i + 1);
         end
      end
      exit_valid = exit_req && (exit_slot != '0) && (exit_slot <= SLOT_W'(NUM_SLOTS));
      timeout    = (cnt_q == CNT_W'(OPEN_CYCLES - 1));
   end

   // Next-state logic. A sensed car always clears its reservation first.
   // Sets and clears from the FSM are then merged on top of that.
   // gate_open follows the state with one cycle of lag, so the barrier
   // moves one cycle after the grant or ack.
   always_comb begin
      state_d         = state_q;
      reserved_d      = reserved_q & ~cars;
      assigned_slot_d = assigned_slot_q;
      entry_grant_d   = 1'b0;
      exit_ack_d      = 1'b0;
      cnt_d           = cnt_q + 1'b1;
      gate_open_d     = (state_q != IDLE);

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (exit_valid) begin
               exit_ack_d = 1'b1;
               reserved_d = reserved_d & ~slot_mask(exit_slot);
               state_d    = EXIT_OPEN;
            end else if (entry_req && !full) begin
               entry_grant_d   = 1'b1;
               assigned_slot_d = free_idx;
               reserved_d      = reserved_d | slot_mask(free_idx);
               state_d         = ENTRY_OPEN;
            end
         end
         ENTRY_OPEN: begin
            // A clear in the same cycle as a timeout counts as a pass,
            // so the reservation is kept.
            if (gate_clear) begin
               state_d = IDLE;
            end else if (timeout) begin
               reserved_d      = reserved_d & ~slot_mask(assigned_slot_q);
               assigned_slot_d = '0;
               state_d         = IDLE;
            end
         end
         EXIT_OPEN: begin
            if (gate_clear || timeout) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         reserved_q      <= '0;
         assigned_slot_q <= '0;
         entry_grant_q   <= 1'b0;
         exit_ack_q      <= 1'b0;
         gate_open_q     <= 1'b0;
         cnt_q           <= '0;
      end else begin
         state_q         <= state_d;
         reserved_q      <= reserved_d;
         assigned_slot_q <= assigned_slot_d;
         entry_grant_q   <= entry_grant_d;
         exit_ack_q      <= exit_ack_d;
         gate_open_q     <= gate_open_d;
         cnt_q           <= cnt_d;
      end
   end

   assign full          = (avail == '0);
   assign entry_grant   = entry_grant_q;
   assign exit_ack      = exit_ack_q;
   assign assigned_slot = assigned_slot_q;
   assign gate_open     = gate_open_q;
   assign reserved      = reserved_q;

endmodule

// File: doc/parking_gate_controller.md
Name: parking_gate_controller

Overview:
- Sequences a single shared entry/exit barrier for the 15-slot car park.
- Arbitrates between entry and exit requests and allocates the lowest-numbered free slot to each entering car.
- Reserves the allocated slot until its occupancy sensor confirms the car, and times out cars that never pass the barrier.
- Sits between the slot sensor bus and the display path: the assigned_slot output feeds the seven-segment decoder.

Parameters:
- NUM_SLOTS, 15, number of parking slots; slot numbers run 1..NUM_SLOTS.
- SLOT_W, 4, width of a slot number; 0 means "no slot".
- OPEN_CYCLES, 8, maximum number of cycles the barrier stays open waiting for gate_clear.
- CNT_W, 4, width of the timeout counter; must satisfy 2^CNT_W > OPEN_CYCLES.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cars  in  NUM_SLOTS  slot occupancy sensors; bit i high means slot i+1 is occupied.
- entry_req  in  1  level request from the entry button; held high until entry_grant or full.
- exit_req  in  1  level request from the exit reader; held high until exit_ack.
- exit_slot  in  SLOT_W  number of the slot being vacated; sampled while exit_req is high.
- gate_clear  in  1  pulse from the barrier beam when a car has passed.
- entry_grant  out  1  one-cycle pulse when a slot has been allocated to an entering car.
- exit_ack  out  1  one-cycle pulse when an exit request is accepted.
- assigned_slot  out  SLOT_W  last allocated slot number; 0 when none.
- gate_open  out  1  barrier open command.
- full  out  1  high when every slot is either occupied or reserved.
- reserved  out  NUM_SLOTS  reservation mask.

Behaviour:
- Reset values (asynchronous): state=IDLE, reserved=0, assigned_slot=0, entry_grant=0, exit_ack=0, gate_open=0, counter=0.
- avail = ~(cars | reserved).
- full = (avail == 0). full is combinational.
- free_idx = lowest set bit of avail, plus 1.
- State machine states: IDLE, ENTRY_OPEN, EXIT_OPEN.
- IDLE, arbitration:
  - exit_req with a valid exit_slot (1..NUM_SLOTS) takes priority over entry_req.
  - Exit accepted: exit_ack pulses for 1 cycle, reserved[exit_slot-1] is cleared, and the next state is EXIT_OPEN.
  - exit_req with exit_slot equal to 0 or greater than NUM_SLOTS: request ignored, no ack, state stays IDLE.
  - entry_req with full=0 (and no valid exit): entry_grant pulses for 1 cycle, assigned_slot=free_idx, reserved bit set, next state ENTRY_OPEN.
  - entry_req with full=1: no grant, state stays IDLE, assigned_slot unchanged.
- gate_open is high exactly while state is ENTRY_OPEN or EXIT_OPEN; it is registered, so it rises 1 cycle after the grant or ack edge.
- Timeout counter: cleared on entering either OPEN state, then increments once per cycle.
- Leaving an OPEN state:
  - gate_clear high -> return to IDLE.
  - counter == OPEN_CYCLES-1 without gate_clear -> timeout, return to IDLE.
  - On an ENTRY_OPEN timeout, the reservation for assigned_slot is released and assigned_slot is set to 0.
- Reservation release:
  - Any reserved bit whose cars bit is 1 is cleared on the next edge, in any state.
  - This clear merges with a same-cycle set of a different bit.
- Requests arriving during an OPEN state are not serviced; they stay pending until the return to IDLE.
- Latency:
  - request to grant/ack is 1 cycle from IDLE.
  - grant to gate_open is 1 cycle.
  - the minimum entry cycle is 3 clocks back to IDLE.
- Simultaneous events:
  - gate_clear and timeout in the same cycle: treated as cleared, so the reservation is kept.
  - A cars bit rising for the assigned slot while still in ENTRY_OPEN: reservation cleared; a later timeout then clears nothing.
- Reset asserted mid-operation: gate closes immediately and all reservations are lost.
- Arithmetic: the index search is a fixed priority encoder over NUM_SLOTS bits with no wrap-around; slot 1 has highest priority.

Test Plan:
- Reset with all cars low, entry_req=1 -> entry_grant pulse, assigned_slot=1, reserved=0x0001, gate_open=1 next cycle; gate_clear -> IDLE, gate_open=0.
- cars=0x7FFE, entry_req=1 -> assigned_slot=1; then cars=0x7FFF -> reserved=0, full=1; a second entry_req -> no grant, state IDLE.
- entry_req and exit_req (exit_slot=5) in the same IDLE cycle -> exit_ack only, gate open; after gate_clear, entry is granted next.
- Entry granted slot 3, no gate_clear -> gate_open high for OPEN_CYCLES=8 cycles, then low; reserved bit 2 cleared; assigned_slot=0.
- exit_req with exit_slot=0 and then with 15 -> no ack for slot 0; ack for 15 with reserved[14] cleared.
- rst asserted during ENTRY_OPEN -> gate_open=0 and reserved=0 immediately, without waiting for a clock edge.
